// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse frame builder.
package morse_pkg;

  localparam int FRAME_SLOTS_DEF = 75;
  localparam int GAP_LETTER_DEF  = 3;
  localparam int DASH_LEN_DEF    = 3;

  localparam logic [5:0] CODE_A          = 6'd0;
  localparam logic [5:0] CODE_DIGIT0     = 6'd26;
  localparam logic [5:0] CODE_WORD_SPACE = 6'd36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_GAP,
    ST_ELEM,
    ST_DONE
  } state_t;

  // pattern bit 0 is the first element sent; a 1 is a dash
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pattern;
  } morse_entry_t;

endpackage

// File: rtl/morse_rom.sv
// Character code to Morse entry lookup; len=0 marks codes with no glyph.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0]   i_code,
  output morse_entry_t o_entry
);

  always_comb begin
    o_entry = {3'd0, 5'b00000};
    case (i_code)
      CODE_A: o_entry = {3'd2, 5'b00010}; // A .-
      6'd1:   o_entry = {3'd4, 5'b00001}; // B -...
      6'd2:   o_entry = {3'd4, 5'b00101}; // C -.-.
      6'd3:   o_entry = {3'd3, 5'b00001}; // D -..
      6'd4:   o_entry = {3'd1, 5'b00000}; // E .
      6'd5:   o_entry = {3'd4, 5'b00100}; // F ..-.
      6'd6:   o_entry = {3'd3, 5'b00011}; // G --.
      6'd7:   o_entry = {3'd4, 5'b00000}; // H ....
      6'd8:   o_entry = {3'd2, 5'b00000}; // I ..
      6'd9:   o_entry = {3'd4, 5'b01110}; // J .---
      6'd10:  o_entry = {3'd3, 5'b00101}; // K -.-
      6'd11:  o_entry = {3'd4, 5'b00010}; // L .-..
      6'd12:  o_entry = {3'd2, 5'b00011}; // M --
      6'd13:  o_entry = {3'd2, 5'b00001}; // N -.
      6'd14:  o_entry = {3'd3, 5'b00111}; // O ---
      6'd15:  o_entry = {3'd4, 5'b00110}; // P .--.
      6'd16:  o_entry = {3'd4, 5'b01011}; // Q --.-
      6'd17:  o_entry = {3'd3, 5'b00010}; // R .-.
      6'd18:  o_entry = {3'd3, 5'b00000}; // S ...
      6'd19:  o_entry = {3'd1, 5'b00001}; // T -
      6'd20:  o_entry = {3'd3, 5'b00100}; // U ..-
      6'd21:  o_entry = {3'd4, 5'b01000}; // V ...-
      6'd22:  o_entry = {3'd3, 5'b00110}; // W .--
      6'd23:  o_entry = {3'd4, 5'b01001}; // X -..-
      6'd24:  o_entry = {3'd4, 5'b01101}; // Y -.--
      6'd25:  o_entry = {3'd4, 5'b00011}; // Z --..
      CODE_DIGIT0: o_entry = {3'd5, 5'b11111}; // 0 -----
      6'd27:  o_entry = {3'd5, 5'b11110}; // 1 .----
      6'd28:  o_entry = {3'd5, 5'b11100}; // 2 ..---
      6'd29:  o_entry = {3'd5, 5'b11000}; // 3 ...--
      6'd30:  o_entry = {3'd5, 5'b10000}; // 4 ....-
      6'd31:  o_entry = {3'd5, 5'b00000}; // 5 .....
      6'd32:  o_entry = {3'd5, 5'b00001}; // 6 -....
      6'd33:  o_entry = {3'd5, 5'b00011}; // 7 --...
      6'd34:  o_entry = {3'd5, 5'b00111}; // 8 ---..
      6'd35:  o_entry = {3'd5, 5'b01111}; // 9 ----.
      default: o_entry = {3'd0, 5'b00000};
    endcase
  end

endmodule

// File: rtl/morse_frame_builder.sv
// Expands character codes into Morse on/off slots packed LSB-first into a frame.
// Optional word space (code 36) enabled by defining MORSE_WORD_SPACE_EN.
module morse_frame_builder
  import morse_pkg::*;
#(
  parameter int FRAME_SLOTS = FRAME_SLOTS_DEF,
  parameter int GAP_LETTER  = GAP_LETTER_DEF,
  parameter int DASH_LEN    = DASH_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   char_valid,
  input  logic [5:0]             char_code,
  output logic                   char_ready,
  input  logic                   commit,
  output logic [FRAME_SLOTS-1:0] beep_bit,
  output logic [6:0]             wid,
  output logic                   frame_valid,
  output logic                   overflow
);

  // state | meaning
  // IDLE  | waiting for a character or a commit
  // CHECK | glyph lookup and fit check
  // GAP   | writing inter-letter low slots
  // ELEM  | writing glyph slots
  // DONE  | applying any pending commit
  localparam int GLYPH_W = 5 * DASH_LEN + 4;
  localparam logic [GLYPH_W-1:0] DOT_MASK   = GLYPH_W'(1);
  localparam logic [GLYPH_W-1:0] DASH_MASK  = GLYPH_W'((1 << DASH_LEN) - 1);
  localparam logic [7:0]         GAP_W      = 8'(GAP_LETTER);
  localparam logic [7:0]         WORD_GAP_W = 8'd7;
  localparam logic [7:0]         SLOTS_W    = 8'(FRAME_SLOTS);

  state_t                 r_state;
  logic [5:0]             r_code;
  logic [6:0]             r_ptr;
  logic [7:0]             r_gap_cnt;
  logic [7:0]             r_rem;
  logic [GLYPH_W-1:0]     r_glyph;
  logic                   r_commit_pend;
  logic                   r_after_space;
  logic                   r_ready;
  logic [FRAME_SLOTS-1:0] r_beep;
  logic [6:0]             r_wid;
  logic                   r_frame_valid;
  logic                   r_overflow;

  morse_entry_t       w_entry;
  logic [GLYPH_W-1:0] w_glyph;
  logic [7:0]         w_glyph_len;
  logic               w_is_space;
  logic               w_ignored;
  logic [7:0]         w_s;
  logic [7:0]         w_g;
  logic               w_fits;
  logic               w_commit_go;

  morse_rom u_rom (
    .i_code  (r_code),
    .o_entry (w_entry)
  );

  // Flatten the element list into a contiguous slot pattern, bit 0 first.
  always_comb begin
    w_glyph     = '0;
    w_glyph_len = '0;
    for (int i = 0; i < 5; i++) begin
      if (3'(i) < w_entry.len) begin
        if (i != 0) w_glyph_len = w_glyph_len + 8'd1;
        if (w_entry.pattern[i]) begin
          w_glyph     = w_glyph | (DASH_MASK << w_glyph_len);
          w_glyph_len = w_glyph_len + 8'(DASH_LEN);
        end else begin
          w_glyph     = w_glyph | (DOT_MASK << w_glyph_len);
          w_glyph_len = w_glyph_len + 8'd1;
        end
      end
    end
  end

`ifdef MORSE_WORD_SPACE_EN
  assign w_is_space = (r_code == CODE_WORD_SPACE) && (r_ptr != 7'd0);
`else
  assign w_is_space = 1'b0;
`endif

  // A word space already separates letters, so the next letter skips its gap.
  assign w_ignored   = (w_entry.len == 3'd0) && !w_is_space;
  assign w_s         = w_is_space ? WORD_GAP_W : w_glyph_len;
  assign w_g         = ((r_ptr == 7'd0) || r_after_space || w_is_space) ? 8'd0 : GAP_W;
  assign w_fits      = ({1'b0, r_ptr} + w_g + w_s) <= SLOTS_W;
  assign w_commit_go = (r_commit_pend || commit) && (r_ptr != 7'd0) && !r_frame_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_code        <= '0;
      r_ptr         <= '0;
      r_gap_cnt     <= '0;
      r_rem         <= '0;
      r_glyph       <= '0;
      r_commit_pend <= 1'b0;
      r_after_space <= 1'b0;
      r_ready       <= 1'b1;
      r_beep        <= '0;
      r_wid         <= '0;
      r_frame_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (commit && (r_state != ST_IDLE)) r_commit_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (char_valid) begin
            r_code        <= char_code;
            r_commit_pend <= commit;
            r_ready       <= 1'b0;
            r_state       <= ST_CHECK;
            if (r_frame_valid) begin
              r_beep        <= '0;
              r_ptr         <= '0;
              r_overflow    <= 1'b0;
              r_frame_valid <= 1'b0;
              r_after_space <= 1'b0;
            end
          end else if (commit && (r_ptr != 7'd0) && !r_frame_valid) begin
            r_wid         <= r_ptr - 7'd1;
            r_frame_valid <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_ignored) begin
            if (w_commit_go) begin
              r_wid         <= r_ptr - 7'd1;
              r_frame_valid <= 1'b1;
            end
            r_commit_pend <= 1'b0;
            r_ready       <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (!w_fits) begin
            r_overflow <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_glyph       <= w_is_space ? '0 : w_glyph;
            r_rem         <= w_s;
            r_gap_cnt     <= w_g;
            r_after_space <= w_is_space;
            r_state       <= (w_g == 8'd0) ? ST_ELEM : ST_GAP;
          end
        end
        ST_GAP: begin
          r_beep[r_ptr] <= 1'b0;
          r_ptr         <= r_ptr + 7'd1;
          r_gap_cnt     <= r_gap_cnt - 8'd1;
          if (r_gap_cnt == 8'd1) r_state <= ST_ELEM;
        end
        ST_ELEM: begin
          r_beep[r_ptr] <= r_glyph[0];
          r_glyph       <= r_glyph >> 1;
          r_ptr         <= r_ptr + 7'd1;
          r_rem         <= r_rem - 8'd1;
          if (r_rem == 8'd1) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (w_commit_go) begin
            r_wid         <= r_ptr - 7'd1;
            r_frame_valid <= 1'b1;
          end
          r_commit_pend <= 1'b0;
          r_ready       <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign char_ready  = r_ready;
  assign beep_bit    = r_beep;
  assign wid         = r_wid;
  assign frame_valid = r_frame_valid;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_morse_frame_builder.sv
// Directed bench for morse_frame_builder with a transaction-level frame model.
module tb_morse_frame_builder;

`ifdef MORSE_WORD_SPACE_EN
  localparam bit WS_EN = 1'b1;
`else
  localparam bit WS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        char_valid;
  logic [5:0]  char_code;
  logic        char_ready;
  logic        commit;
  logic [74:0] beep_bit;
  logic [6:0]  wid;
  logic        frame_valid;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  morse_frame_builder dut (
    .clk         (clk),
    .rst         (rst),
    .char_valid  (char_valid),
    .char_code   (char_code),
    .char_ready  (char_ready),
    .commit      (commit),
    .beep_bit    (beep_bit),
    .wid         (wid),
    .frame_valid (frame_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  string MORSE [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };

  // Model state: frame contents, fill pointer and how many more cycles the DUT stays busy.
  logic [74:0] m_beep;
  int          m_ptr;
  logic [6:0]  m_wid;
  logic        m_fv;
  logic        m_ovf;
  int          m_busy;
  logic        m_pend;
  logic        m_after_sp;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_beep = '0; m_ptr = 0; m_wid = '0; m_fv = 1'b0; m_ovf = 1'b0;
    m_busy = 0; m_pend = 1'b0; m_after_sp = 1'b0;
  endtask

  task automatic model_publish();
    if (m_ptr > 0 && !m_fv) begin
      m_fv  = 1'b1;
      m_wid = 7'(m_ptr - 1);
    end
  endtask

  task automatic model_accept(input int code);
    bit    slots[$];
    int    g;
    bit    is_sp;
    string s;
    if (m_fv) begin
      m_beep = '0; m_ptr = 0; m_ovf = 1'b0; m_fv = 1'b0; m_after_sp = 1'b0;
    end
    is_sp = WS_EN && (code == 36) && (m_ptr > 0);
    if (code < 36 || is_sp) begin
      if (is_sp) begin
        g = 0;
        repeat (7) slots.push_back(1'b0);
      end else begin
        g = (m_ptr == 0 || m_after_sp) ? 0 : 3;
        s = MORSE[code];
        for (int i = 0; i < s.len(); i++) begin
          if (i > 0) slots.push_back(1'b0);
          if (s.getc(i) == "-") repeat (3) slots.push_back(1'b1);
          else slots.push_back(1'b1);
        end
      end
      if (m_ptr + g + slots.size() > 75) begin
        m_ovf  = 1'b1;
        m_busy = 2;
      end else begin
        m_busy = 2 + g + slots.size();
        repeat (g) begin m_beep[m_ptr] = 1'b0; m_ptr++; end
        foreach (slots[k]) begin m_beep[m_ptr] = slots[k]; m_ptr++; end
        m_after_sp = is_sp;
      end
    end else begin
      m_busy = 1;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (m_busy > 0) begin
      if (commit) m_pend = 1'b1;
      m_busy--;
      if (m_busy == 0) begin
        if (m_pend) model_publish();
        m_pend = 1'b0;
      end
    end else if (char_valid) begin
      model_accept(int'(char_code));
      m_pend = commit;
    end else if (commit) begin
      model_publish();
    end
  endtask

  task automatic compare();
    if (m_busy > 0) begin
      chk("ready_busy", 128'(char_ready), 128'(1'b0));
      chk("fv_busy", 128'(frame_valid), 128'(m_fv));
    end else begin
      chk("ready_idle", 128'(char_ready), 128'(1'b1));
      chk("beep", 128'(beep_bit), 128'(m_beep));
      chk("frame_valid", 128'(frame_valid), 128'(m_fv));
      chk("overflow", 128'(overflow), 128'(m_ovf));
      if (m_fv) chk("wid", 128'(wid), 128'(m_wid));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_idle(output int lows);
    lows = 0;
    while (!char_ready && lows < 100) begin
      lows++;
      tick();
    end
    if (!char_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: char_ready still low after %0d cycles", lows);
    end
  endtask

  task automatic send(input int code, input bit with_commit);
    int lows;
    wait_idle(lows);
    char_valid = 1'b1;
    char_code  = 6'(code);
    commit     = with_commit;
    tick();
    char_valid = 1'b0;
    commit     = 1'b0;
  endtask

  task automatic do_commit();
    int lows;
    wait_idle(lows);
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  initial begin
    int lows;
    rst = 1'b1; char_valid = 1'b0; char_code = '0; commit = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 128'(char_ready), 128'(1'b1));
    chk("rst_beep", 128'(beep_bit), 128'(0));

    do_commit();
    chk("commit_empty_fv", 128'(frame_valid), 128'(1'b0));

    // E alone
    send(4, 1'b0);
    wait_idle(lows);
    chk("lat_E", 128'(lows), 128'(3));
    do_commit();
    chk("E_beep", 128'(beep_bit), 128'(75'h1));
    chk("E_wid", 128'(wid), 128'(7'd0));
    chk("E_fv", 128'(frame_valid), 128'(1'b1));
    do_commit();
    chk("recommit_wid", 128'(wid), 128'(7'd0));

    // E then T: gap of 3 before T
    send(4, 1'b0);
    send(19, 1'b0);
    wait_idle(lows);
    chk("lat_T", 128'(lows), 128'(8));
    do_commit();
    chk("ET_beep", 128'(beep_bit), 128'(75'h71));
    chk("ET_wid", 128'(wid), 128'(7'd6));

    // A with commit in the acceptance cycle
    send(0, 1'b1);
    wait_idle(lows);
    chk("A_fv", 128'(frame_valid), 128'(1'b1));
    chk("A_beep", 128'(beep_bit), 128'(75'h1D));
    chk("A_wid", 128'(wid), 128'(7'd4));

    // Five zeros: three fit (ptr 63), the rest overflow
    for (int i = 0; i < 5; i++) send(26, 1'b0);
    wait_idle(lows);
    chk("zeros_ovf", 128'(overflow), 128'(1'b1));
    chk("zeros_fv", 128'(frame_valid), 128'(1'b0));
    do_commit();
    chk("zeros_wid", 128'(wid), 128'(7'd62));

    // S with commit raised mid-expansion
    send(18, 1'b0);
    tick();
    tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_idle(lows);
    chk("S_fv", 128'(frame_valid), 128'(1'b1));
    chk("S_beep", 128'(beep_bit), 128'(75'h15));
    chk("S_wid", 128'(wid), 128'(7'd4));

    // E, ignored code, code 36, E
    send(4, 1'b0);
    send(40, 1'b0);
    wait_idle(lows);
    chk("lat_ignored", 128'(lows), 128'(1));
    send(36, 1'b0);
    send(4, 1'b0);
    do_commit();
    chk("ws_wid", 128'(wid), 128'(WS_EN ? 7'd8 : 7'd4));
    chk("ws_beep", 128'(beep_bit), 128'(WS_EN ? 75'h101 : 75'h11));

    // Reset in the middle of Q
    send(16, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rstmid_ready", 128'(char_ready), 128'(1'b1));
    chk("rstmid_beep", 128'(beep_bit), 128'(0));
    chk("rstmid_fv", 128'(frame_valid), 128'(1'b0));
    rst = 1'b0;
    tick();
    send(4, 1'b0);
    do_commit();
    chk("after_rst_wid", 128'(wid), 128'(7'd0));
    chk("after_rst_beep", 128'(beep_bit), 128'(75'h1));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
